// File: rtl/dlfloat_pkg.sv
// Shared constants for the DLFloat sign-manipulation unit.
//   - op codes carried on the 3-bit sel bus
//   - default lane geometry (1 sign, 6 exponent, 9 mantissa bits)
//   - default unit-select code
//   - bit positions inside the 5-bit {NV,DZ,OF,UF,NX} exception vector
package dlfloat_pkg;

  localparam int EXP_W_DEF = 6;
  localparam int MAN_W_DEF = 9;

  localparam logic [3:0] UNIT_ID_DEF = 4'b0101;

  localparam logic [2:0] OP_NEG   = 3'd0;
  localparam logic [2:0] OP_SGNJ  = 3'd1;
  localparam logic [2:0] OP_SGNJN = 3'd2;
  localparam logic [2:0] OP_SGNJX = 3'd3;
  localparam logic [2:0] OP_ABS   = 3'd4;
  localparam logic [2:0] OP_MOV   = 3'd5;

  localparam int FLAG_W  = 5;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/dlfloat_sign_lane.sv
// Single DLFloat lane: combinational sign-injection / negate / abs / move
// plus invalid-operation detection.
//   sel : op code (dlfloat_pkg OP_*), 110/111 reserved
//   a   : first operand  (sign + exponent + mantissa)
//   b   : second operand
//   res : lane result (zero for reserved op codes)
//   nv  : invalid flag -- reserved op, or an operand actually read by the op
//         has the all-ones exponent/mantissa pattern
module dlfloat_sign_lane
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [2:0]           sel,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 nv
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic             sign_a;
  logic             sign_b;
  logic [W-2:0]     mag_a;
  logic [W-2:0]     mag_b;
  logic             nan_a;
  logic             nan_b;
  logic             reads_b;
  logic             rsvd;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1];
  assign mag_a  = a[W-2:0];
  assign mag_b  = b[W-2:0];
  assign nan_a  = &mag_a;
  assign nan_b  = &mag_b;

  // The sign-injection ops consume both operands (sign of a, magnitude of b),
  // so a NaN pattern on either one raises NV; the single-operand ops ignore b.
  always_comb begin
    res     = '0;
    reads_b = 1'b0;
    rsvd    = 1'b0;
    case (sel)
      OP_NEG:   res = {~sign_a, mag_a};
      OP_SGNJ:  begin res = {sign_a, mag_b};          reads_b = 1'b1; end
      OP_SGNJN: begin res = {~sign_a, mag_b};         reads_b = 1'b1; end
      OP_SGNJX: begin res = {sign_a ^ sign_b, mag_b}; reads_b = 1'b1; end
      OP_ABS:   res = {1'b0, mag_a};
      OP_MOV:   res = a;
      default:  rsvd = 1'b1;
    endcase
  end

  assign nv = rsvd | nan_a | (reads_b & nan_b);

endmodule

// File: rtl/dlfloat_sign_pipe.sv
// Two-stage DLFloat sign-manipulation unit with valid/ready handshakes.
//   clk, rst_n  : clock, asynchronous active-low reset (clears valids only)
//   in_valid    : request beat present
//   in_ready    : unit can take a beat (depends only on pipeline state and
//                 out_ready, never on the input side)
//   ena         : unit select, a beat is taken only when ena == UNIT_ID;
//                 other beats are dropped without stalling
//   sel         : op code shared by all lanes
//   in1, in2    : LANES packed operands, lane k at [k*W +: W]
//   out_valid   : result beat present
//   out_ready   : downstream accepts the result
//   out         : LANES packed results, zero whenever out_valid is low
//   exceptions  : {NV,DZ,OF,UF,NX}, NV ORed across lanes, zero when idle
module dlfloat_sign_pipe
  import dlfloat_pkg::*;
#(
  parameter int         EXP_W   = EXP_W_DEF,
  parameter int         MAN_W   = MAN_W_DEF,
  parameter int         LANES   = 1,
  parameter logic [3:0] UNIT_ID = UNIT_ID_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [3:0]                     ena,
  input  logic [2:0]                     sel,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in1,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] out,
  output logic [FLAG_W-1:0]              exceptions
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BUS_W = LANES * W;

  logic              vld_p1;
  logic              vld_p2;
  logic [2:0]        sel_p1;
  logic [BUS_W-1:0]  in1_p1;
  logic [BUS_W-1:0]  in2_p1;
  logic [BUS_W-1:0]  res_p2;
  logic [FLAG_W-1:0] exc_p2;

  logic              adv_p2;
  logic              accept;
  logic [BUS_W-1:0]  res_c;
  logic [LANES-1:0]  nv_c;
  logic [FLAG_W-1:0] exc_c;

  // S2 can take new data when empty or draining; S1 frees whenever S2 can take it.
  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign accept   = in_valid && in_ready && (ena == UNIT_ID);

  // ---- stage boundary p1: operand / op-code capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= accept;
      if (adv_p2)   vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p1 <= sel;
      in1_p1 <= in1;
      in2_p1 <= in2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dlfloat_sign_lane #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
    ) u_lane (
      .sel (sel_p1),
      .a   (in1_p1[k*W +: W]),
      .b   (in2_p1[k*W +: W]),
      .res (res_c[k*W +: W]),
      .nv  (nv_c[k])
    );
  end

  always_comb begin
    exc_c          = '0;
    exc_c[FLAG_NV] = |nv_c;
  end

  // ---- stage boundary p2: result / flag capture ----
  always_ff @(posedge clk) begin
    if (adv_p2 && vld_p1) begin
      res_p2 <= res_c;
      exc_p2 <= exc_c;
    end
  end

  assign out_valid  = vld_p2;
  assign out        = vld_p2 ? res_p2 : '0;
  assign exceptions = vld_p2 ? exc_p2 : '0;

endmodule
